// File: rtl/ntt_mult_arbiter.sv
// Round-robin owner arbiter and job sequencer for one shared NTT multiplier.
// Optional watchdog on stalled owners: define NTT_ARB_WATCHDOG_EN.
module ntt_mult_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int WDOG_CYCLES = 65535,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           release_i,
  input  logic [NUM_REQ-1:0]           req_load_coeff,
  input  logic [NUM_REQ-1:0]           req_load_sel,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_load_addr,
  input  logic [NUM_REQ*WIDTH-1:0]     req_load_data,
  input  logic [NUM_REQ-1:0]           req_start,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_read_addr,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           req_done,
  output logic [WIDTH-1:0]             req_read_data,
  output logic [IW-1:0]                owner_id,
  output logic [15:0]                  jobs_done,
  output logic                         wdog_err,
  output logic                         eng_start,
  output logic                         eng_load_coeff,
  output logic                         eng_load_sel,
  output logic [ADDR_WIDTH-1:0]        eng_load_addr,
  output logic [WIDTH-1:0]             eng_load_data,
  output logic [ADDR_WIDTH-1:0]        eng_read_addr,
  input  logic                         eng_done,
  input  logic                         eng_busy,
  input  logic [WIDTH-1:0]             eng_read_data
);

  if (NUM_REQ < 2 || WDOG_CYCLES < 1) begin : g_bad_param
    $error("ntt_mult_arbiter: bad parameters");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_READ
  } state_t;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   rr_next;
  logic [IW-1:0]   pick;
  logic            wdog_hit;

  logic [ADDR_WIDTH-1:0] ld_addr [NUM_REQ];
  logic [WIDTH-1:0]      ld_data [NUM_REQ];
  logic [ADDR_WIDTH-1:0] rd_addr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign ld_addr[g] = req_load_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign ld_data[g] = req_load_data[g*WIDTH +: WIDTH];
    assign rd_addr[g] = req_read_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

  logic own_req;
  logic own_rel;
  logic own_start;
  logic in_load;
  logic in_read;

  assign own_req   = req[owner_id];
  assign own_rel   = release_i[owner_id];
  assign own_start = req_start[owner_id];
  assign in_load   = (state == S_LOAD);
  assign in_read   = (state == S_READ);

  assign rr_next = (owner_id == IW'(NUM_REQ - 1)) ?
                   '0 : owner_id + 1'b1;

  // First requester at or above rr_ptr, wrapping around.
  always_comb begin
    int          idx;
    logic [IW-1:0] cand;
    logic        found;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IW'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      owner_id  <= '0;
      grant     <= '0;
      req_done  <= '0;
      eng_start <= 1'b0;
      jobs_done <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (|req && !eng_busy) begin
            state    <= S_LOAD;
            owner_id <= pick;
            grant    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
          end
        end
        S_LOAD: begin
          if (own_rel || !own_req || wdog_hit) begin
            state  <= S_IDLE;
            grant  <= '0;
            rr_ptr <= rr_next;
          end else if (own_start) begin
            state     <= S_RUN;
            eng_start <= 1'b1;
          end
        end
        S_RUN: begin
          if (eng_done) begin
            state     <= S_READ;
            eng_start <= 1'b0;
            req_done  <= grant;
            jobs_done <= jobs_done + 16'd1;
          end
        end
        S_READ: begin
          if (own_rel || wdog_hit) begin
            state    <= S_IDLE;
            grant    <= '0;
            req_done <= '0;
            rr_ptr   <= rr_next;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef NTT_ARB_WATCHDOG_EN
  logic [31:0] wdog_cnt;

  assign wdog_hit = (in_load || in_read) &&
                    (wdog_cnt + 32'd1 == 32'(WDOG_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt <= '0;
      wdog_err <= 1'b0;
    end else begin
      wdog_err <= 1'b0;
      if (in_load || in_read)
        wdog_cnt <= wdog_cnt + 32'd1;
      else
        wdog_cnt <= '0;
      // Only flag a release the owner did not ask for itself.
      if (in_load && wdog_hit && own_req && !own_rel)
        wdog_err <= 1'b1;
      if (in_read && wdog_hit && !own_rel)
        wdog_err <= 1'b1;
    end
  end
`else
  assign wdog_hit = 1'b0;
  assign wdog_err = 1'b0;
`endif

  always_comb begin
    eng_load_coeff = 1'b0;
    eng_load_sel   = 1'b0;
    eng_load_addr  = '0;
    eng_load_data  = '0;
    eng_read_addr  = '0;
    unique case (1'b1)
      in_load: begin
        eng_load_coeff = req_load_coeff[owner_id];
        eng_load_sel   = req_load_sel[owner_id];
        eng_load_addr  = ld_addr[owner_id];
        eng_load_data  = ld_data[owner_id];
      end
      in_read: begin
        eng_read_addr = rd_addr[owner_id];
      end
      default: begin
        eng_read_addr = '0;
      end
    endcase
  end

  assign req_read_data = eng_read_data;

endmodule

// File: tb/tb_ntt_mult_arbiter.sv
// Bench for ntt_mult_arbiter with a small negacyclic multiplier model.
// Result reads are checked through a queue of expected words.
module tb_ntt_mult_arbiter;

  localparam int NR = 4;
  localparam int W  = 32;
  localparam int AW = 8;
  localparam int N  = 4;
  localparam int WD = 16;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req;
  logic [NR-1:0]     release_i;
  logic [NR-1:0]     req_load_coeff;
  logic [NR-1:0]     req_load_sel;
  logic [NR*AW-1:0]  req_load_addr;
  logic [NR*W-1:0]   req_load_data;
  logic [NR-1:0]     req_start;
  logic [NR*AW-1:0]  req_read_addr;
  logic [NR-1:0]     grant;
  logic [NR-1:0]     req_done;
  logic [W-1:0]      req_read_data;
  logic [1:0]        owner_id;
  logic [15:0]       jobs_done;
  logic              wdog_err;
  logic              eng_start;
  logic              eng_load_coeff;
  logic              eng_load_sel;
  logic [AW-1:0]     eng_load_addr;
  logic [W-1:0]      eng_load_data;
  logic [AW-1:0]     eng_read_addr;
  logic              eng_done;
  logic              eng_busy;
  logic [W-1:0]      eng_read_data;

  logic              eng_busy_m;
  logic              force_busy;
  logic [2:0]        eng_cnt;
  logic [W-1:0]      a_mem [N];
  logic [W-1:0]      b_mem [N];
  logic [W-1:0]      r_mem [N];

  int                n_vec;
  int                n_err;
  logic [W-1:0]      exp_q [$];

  assign eng_busy = eng_busy_m | force_busy;

  ntt_mult_arbiter #(
    .NUM_REQ(NR), .WIDTH(W), .ADDR_WIDTH(AW),
    .WDOG_CYCLES(WD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req(req), .release_i(release_i),
    .req_load_coeff(req_load_coeff),
    .req_load_sel(req_load_sel),
    .req_load_addr(req_load_addr),
    .req_load_data(req_load_data),
    .req_start(req_start),
    .req_read_addr(req_read_addr),
    .grant(grant), .req_done(req_done),
    .req_read_data(req_read_data),
    .owner_id(owner_id), .jobs_done(jobs_done),
    .wdog_err(wdog_err),
    .eng_start(eng_start),
    .eng_load_coeff(eng_load_coeff),
    .eng_load_sel(eng_load_sel),
    .eng_load_addr(eng_load_addr),
    .eng_load_data(eng_load_data),
    .eng_read_addr(eng_read_addr),
    .eng_done(eng_done), .eng_busy(eng_busy),
    .eng_read_data(eng_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine model: done holds until start drops.
  always @(posedge clk or negedge rst_n) begin
    logic [W-1:0] t [N];
    int k;
    if (!rst_n) begin
      eng_busy_m    <= 1'b0;
      eng_done      <= 1'b0;
      eng_cnt       <= '0;
      eng_read_data <= '0;
      for (int i = 0; i < N; i++) begin
        a_mem[i] <= '0;
        b_mem[i] <= '0;
        r_mem[i] <= '0;
      end
    end else begin
      if (eng_load_coeff) begin
        if (eng_load_sel) b_mem[eng_load_addr[1:0]] <= eng_load_data;
        else              a_mem[eng_load_addr[1:0]] <= eng_load_data;
      end
      eng_read_data <= r_mem[eng_read_addr[1:0]];
      if (eng_done) begin
        if (!eng_start) eng_done <= 1'b0;
      end else if (eng_busy_m) begin
        if (eng_cnt == 0) begin
          for (int i = 0; i < N; i++) t[i] = '0;
          for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
              k = i + j;
              if (k < N) t[k] = t[k] + a_mem[i] * b_mem[j];
              else t[k-N] = t[k-N] - a_mem[i] * b_mem[j];
            end
          for (int i = 0; i < N; i++) r_mem[i] <= t[i];
          eng_busy_m <= 1'b0;
          eng_done   <= 1'b1;
        end else begin
          eng_cnt <= eng_cnt - 3'd1;
        end
      end else if (eng_start) begin
        eng_busy_m <= 1'b1;
        eng_cnt    <= 3'd4;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in;
    req            = '0;
    release_i      = '0;
    req_load_coeff = '0;
    req_load_sel   = '0;
    req_load_addr  = '0;
    req_load_data  = '0;
    req_start      = '0;
    req_read_addr  = '0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    force_busy = 1'b0;
    clr_in();
    rst_n = 1'b0;
    #12;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_start", 32'(eng_start), 0);
    chk("rst_jobs", 32'(jobs_done), 0);
    chk("rst_wdog", 32'(wdog_err), 0);
    chk("rst_owner", 32'(owner_id), 0);
    chk("rst_done", 32'(req_done), 0);
    rst_n = 1'b1;
    step();
    req = 4'b0001;
    chk("pre_grant", 32'(grant), 0);
    step();
    chk("grant0", 32'(grant), 32'b0001);
    release_i = 4'b0001;
    req = '0;
    step();
    chk("rel0", 32'(grant), 0);
    release_i = '0;

    req = 4'b0100;
    step();
    chk("grant2", 32'(grant), 32'b0100);
    chk("owner2", 32'(owner_id), 2);
    for (int i = 0; i < N; i++) begin
      req_load_coeff = 4'b0100;
      req_load_sel   = 4'b0000;
      req_load_addr[2*AW +: AW] = AW'(i);
      req_load_data[2*W +: W]   = 32'(i);
      #1;
      chk("ld_data", eng_load_data, 32'(i));
      step();
    end
    req_load_coeff = 4'b0010;
    req_load_addr[1*AW +: AW] = 8'd1;
    req_load_data[1*W +: W]   = 32'd7;
    #1;
    chk("drop_ld", 32'(eng_load_coeff), 0);
    step();
    for (int i = 0; i < N; i++) begin
      req_load_coeff = 4'b0100;
      req_load_sel   = 4'b0100;
      req_load_addr[2*AW +: AW] = AW'(i);
      req_load_data[2*W +: W]   = (i == 0) ? 32'd1 : 32'd0;
      if (i == N - 1) req_start = 4'b0100;
      step();
    end
    req_start = '0;
    chk("start", 32'(eng_start), 1);
    chk("run_ld", 32'(eng_load_coeff), 0);
    req_load_coeff = '0;
    release_i = 4'b0100;
    for (int k = 0; k < 50 && !req_done[2]; k++) step();
    release_i = '0;
    chk("done", 32'(req_done), 32'b0100);
    chk("run_hold", 32'(grant), 32'b0100);
    chk("start_low", 32'(eng_start), 0);
    chk("jobs1", 32'(jobs_done), 1);
    for (int i = 0; i < N; i++) begin
      req_read_addr[2*AW +: AW] = AW'(i);
      #1;
      chk("rd_addr", 32'(eng_read_addr), 32'(i));
      exp_q.push_back(32'(i));
      step();
      chk("rd_data", req_read_data, exp_q.pop_front());
    end
    release_i = 4'b0100;
    req = '0;
    step();
    chk("rel2_g", 32'(grant), 0);
    chk("rel2_d", 32'(req_done), 0);
    chk("rel2_ra", 32'(eng_read_addr), 0);
    release_i = '0;

    req = 4'b0010;
    step();
    chk("grant1", 32'(grant), 32'b0010);
    req_start = 4'b0010;
    release_i = 4'b0010;
    step();
    chk("relwin_g", 32'(grant), 0);
    chk("relwin_s", 32'(eng_start), 0);
    clr_in();

    force_busy = 1'b1;
    req = 4'b1000;
    step();
    step();
    chk("busy_blk", 32'(grant), 0);
    force_busy = 1'b0;
    step();
    chk("busy_free", 32'(grant), 32'b1000);
    release_i = 4'b1000;
    req = '0;
    step();
    release_i = '0;

    rst_n = 1'b0;
    #2;
    chk("rst2_jobs", 32'(jobs_done), 0);
    rst_n = 1'b1;
    step();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_grant", 32'(grant), 32'(1 << (k % 4)));
      release_i = 4'(1 << (k % 4));
      step();
      chk("rr_gap", 32'(grant), 0);
      release_i = '0;
    end
    req = '0;
    step();

`ifdef NTT_ARB_WATCHDOG_EN
    begin
      int n;
      n = 0;
      req = 4'b0001;
      step();
      for (int k = 0; k < 40 && grant[0] && !wdog_err; k++) begin
        n++;
        step();
      end
      chk("wd_cycles", 32'(n), 32'(WD));
      chk("wd_err", 32'(wdog_err), 1);
      chk("wd_grant", 32'(grant), 0);
      req = '0;
      step();
      chk("wd_pulse", 32'(wdog_err), 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
